// File: rtl/posit_packer_pkg.sv
// Shared posit constants, widths and FSM encoding for the posit packer.
package posit_packer_pkg;

    localparam int unsigned N         = 32;
    localparam int unsigned ES        = 3;
    localparam int unsigned K_BITS    = 6;
    localparam int unsigned MAX_BITS  = ES + K_BITS;
    localparam int unsigned FRAC_BITS = N - 3 - ES;

    localparam int EXP_MAX = (1 << MAX_BITS) - 1;
    localparam int EXP_MIN = -(1 << MAX_BITS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SPLIT = 2'd1,
        ST_PACK  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [N-1:0] NAR_WORD    = {1'b1, {(N-1){1'b0}}};
    localparam logic [N-1:0] MAXPOS_WORD = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] MINPOS_WORD = N'(1);

endpackage

// File: rtl/posit_packer_if.sv
// Request/result bundle between a posit packer and its producer/consumer.
interface posit_packer_if #(
    parameter int unsigned N         = posit_packer_pkg::N,
    parameter int unsigned MAX_BITS  = posit_packer_pkg::MAX_BITS,
    parameter int unsigned FRAC_BITS = posit_packer_pkg::FRAC_BITS
);
    logic                        start;
    logic signed [MAX_BITS:0]    exp_raw;
    logic [FRAC_BITS-1:0]        frac_in;
    logic                        sign_in;
    logic                        NaR_in;
    logic                        zero_in;
    logic                        valid_out;
    logic [N-1:0]                posit_out;
    logic                        done;

    modport master (
        output start, exp_raw, frac_in, sign_in, NaR_in, zero_in, valid_out,
        input  posit_out, done
    );

    modport slave (
        input  start, exp_raw, frac_in, sign_in, NaR_in, zero_in, valid_out,
        output posit_out, done
    );
endinterface

// File: rtl/posit_packer_regime_encoder.sv
// Combinational posit body builder: regime run, exponent, fraction, with
// saturation to maxpos/minpos magnitude when the regime does not fit.
module regime_encoder #(
    parameter int unsigned N         = posit_packer_pkg::N,
    parameter int unsigned ES        = posit_packer_pkg::ES,
    parameter int unsigned MAX_BITS  = posit_packer_pkg::MAX_BITS,
    parameter int unsigned FRAC_BITS = posit_packer_pkg::FRAC_BITS
) (
    input  logic signed [MAX_BITS:0] i_k,
    input  logic [ES-1:0]            i_e,
    input  logic [FRAC_BITS-1:0]     i_frac,
    output logic [N-2:0]             o_body
);
    localparam int unsigned PAD = N - 2 - ES - FRAC_BITS;
    localparam logic signed [MAX_BITS:0] K_HI = (MAX_BITS+1)'(N - 2);
    localparam logic signed [MAX_BITS:0] K_LO = (MAX_BITS+1)'(-(int'(N) - 1));

    logic               w_r;
    logic [MAX_BITS:0]  w_run;
    logic [N-2:0]       w_term;
    logic [N-2:0]       w_fill;

    // Terminator + tail pre-aligned at the MSB, then pushed right by the run length.
    always_comb begin
        w_r    = ~i_k[MAX_BITS];
        w_run  = w_r ? ($unsigned(i_k) + (MAX_BITS+1)'(1)) : $unsigned(-i_k);
        w_term = {~w_r, i_e, i_frac, {PAD{1'b0}}};
        w_fill = w_r ? ~({(N-1){1'b1}} >> w_run) : '0;
        o_body = (w_term >> w_run) | w_fill;
        if (i_k >= K_HI) begin
            o_body = '1;
        end else if (i_k <= K_LO) begin
            o_body = (N-1)'(1);
        end
    end

endmodule

// File: rtl/posit_packer.sv
// Multi-cycle posit packer: latches operands, splits the exponent into
// regime/exponent, encodes the body and applies sign/special-value handling.
module posit_packer
    import posit_packer_pkg::*;
#(
    parameter int unsigned N         = posit_packer_pkg::N,
    parameter int unsigned ES        = posit_packer_pkg::ES,
    parameter int unsigned K_BITS    = posit_packer_pkg::K_BITS,
    parameter int unsigned MAX_BITS  = ES + K_BITS,
    parameter int unsigned FRAC_BITS = N - 3 - ES
) (
    input  logic           clk,
    input  logic           rst_n,
    posit_packer_if.slave  bus
);
    localparam logic [N-1:0] NAR_W = {1'b1, {(N-1){1'b0}}};

    state_e                   r_state;
    state_e                   w_next;
    logic                     w_latch;
    logic                     w_split;
    logic                     w_load;
    logic                     w_ack;

    logic signed [MAX_BITS:0] r_exp;
    logic signed [MAX_BITS:0] r_k;
    logic [ES-1:0]            r_e;
    logic [FRAC_BITS-1:0]     r_frac;
    logic                     r_sign;
    logic                     r_nar;
    logic                     r_zero;

    logic [N-2:0]             w_body;
    logic [N-1:0]             w_mag;
    logic [N-1:0]             w_word;
    logic [N-1:0]             r_posit;
    logic                     r_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (bus.start)     w_next = ST_SPLIT;
            ST_SPLIT:                    w_next = ST_PACK;
            ST_PACK:                     w_next = ST_DONE;
            ST_DONE:  if (bus.valid_out) w_next = ST_IDLE;
            default:                     w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_latch = 1'b0;
        w_split = 1'b0;
        w_load  = 1'b0;
        w_ack   = 1'b0;
        case (r_state)
            ST_IDLE:  w_latch = bus.start;
            ST_SPLIT: w_split = 1'b1;
            ST_PACK:  w_load  = 1'b1;
            ST_DONE:  w_ack   = bus.valid_out;
            default:  ;
        endcase
    end

    // Operand capture, then floor split of the combined exponent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_exp  <= '0;
            r_frac <= '0;
            r_sign <= 1'b0;
            r_nar  <= 1'b0;
            r_zero <= 1'b0;
            r_k    <= '0;
            r_e    <= '0;
        end else begin
            if (w_latch) begin
                r_exp  <= bus.exp_raw;
                r_frac <= bus.frac_in;
                r_sign <= bus.sign_in;
                r_nar  <= bus.NaR_in;
                r_zero <= bus.zero_in;
            end
            if (w_split) begin
                r_k <= r_exp >>> ES;
                r_e <= r_exp[ES-1:0];
            end
        end
    end

    regime_encoder #(
        .N         (N),
        .ES        (ES),
        .MAX_BITS  (MAX_BITS),
        .FRAC_BITS (FRAC_BITS)
    ) u_regime_encoder (
        .i_k    (r_k),
        .i_e    (r_e),
        .i_frac (r_frac),
        .o_body (w_body)
    );

    // NaR beats zero beats the signed magnitude; sign is irrelevant for specials.
    always_comb begin
        w_mag  = {1'b0, w_body};
        w_word = w_mag;
        if (r_nar) begin
            w_word = NAR_W;
        end else if (r_zero) begin
            w_word = '0;
        end else if (r_sign) begin
            w_word = ~w_mag + N'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_posit <= '0;
            r_done  <= 1'b0;
        end else if (w_load) begin
            r_posit <= w_word;
            r_done  <= 1'b1;
        end else if (w_ack) begin
            r_done  <= 1'b0;
        end
    end

    assign bus.posit_out = r_posit;
    assign bus.done      = r_done;

endmodule

// File: tb/tb_posit_packer.sv
// Directed and randomized checks of posit_packer against a bit-list posit model.
module tb_posit_packer;
    import posit_packer_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   vectors     = 0;
    int   miscompares = 0;

    posit_packer_if bus ();

    posit_packer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, expv);
        end
    endtask

    // Posit value built as an explicit list of bits from floor(exp / 2^ES).
    function automatic logic [N-1:0] ref_posit(input int ex, input logic [FRAC_BITS-1:0] fr,
                                               input bit s, input bit nar, input bit z);
        int            k;
        int            e;
        bit            q[$];
        logic [N-1:0]  mag;
        if (nar) return NAR_WORD;
        if (z)   return '0;
        k = (ex >= 0) ? ex / (1 << ES) : -((-ex + (1 << ES) - 1) / (1 << ES));
        e = ex - k * (1 << ES);
        if (k >= int'(N) - 2) begin
            mag = MAXPOS_WORD;
        end else if (k <= -(int'(N) - 1)) begin
            mag = MINPOS_WORD;
        end else begin
            if (k >= 0) begin
                repeat (k + 1) q.push_back(1'b1);
                q.push_back(1'b0);
            end else begin
                repeat (-k) q.push_back(1'b0);
                q.push_back(1'b1);
            end
            for (int i = int'(ES) - 1; i >= 0; i--) q.push_back(bit'((e >> i) & 1));
            for (int i = int'(FRAC_BITS) - 1; i >= 0; i--) q.push_back(fr[i]);
            mag = '0;
            for (int i = 0; i < int'(N) - 1; i++) mag = {mag[N-2:0], q[i]};
        end
        return s ? (~mag + N'(1)) : mag;
    endfunction

    // Issue one request and check done timing and the packed word; leaves it in DONE.
    task automatic launch(input int ex, input logic [FRAC_BITS-1:0] fr, input bit s,
                          input bit nar, input bit z, input logic [N-1:0] expv, input string tag);
        @(negedge clk);
        bus.exp_raw = (MAX_BITS+1)'(ex);
        bus.frac_in = fr;
        bus.sign_in = s;
        bus.NaR_in  = nar;
        bus.zero_in = z;
        bus.start   = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check({tag, "/done_e1"}, N'(bus.done), N'(0));
        @(negedge clk);
        check({tag, "/done_e2"}, N'(bus.done), N'(0));
        @(negedge clk);
        check({tag, "/done_e3"}, N'(bus.done), N'(1));
        check({tag, "/posit"}, bus.posit_out, expv);
    endtask

    task automatic ack(input string tag);
        bus.valid_out = 1'b1;
        @(negedge clk);
        bus.valid_out = 1'b0;
        check({tag, "/ack_done"}, N'(bus.done), N'(0));
    endtask

    initial begin
        int                   ex;
        logic [FRAC_BITS-1:0] fr;
        bit                   s;
        bit                   nar;
        bit                   z;
        logic [N-1:0]         expv;

        bus.start     = 1'b0;
        bus.exp_raw   = '0;
        bus.frac_in   = '0;
        bus.sign_in   = 1'b0;
        bus.NaR_in    = 1'b0;
        bus.zero_in   = 1'b0;
        bus.valid_out = 1'b0;

        repeat (2) @(negedge clk);
        check("reset/done", N'(bus.done), N'(0));
        check("reset/posit", bus.posit_out, N'(0));
        rst_n = 1'b1;

        launch(0, '0, 1'b0, 1'b0, 1'b0, 32'h4000_0000, "one");             ack("one");
        launch(9, '0, 1'b0, 1'b0, 1'b0, 32'h6200_0000, "exp9");            ack("exp9");
        launch(-1, '0, 1'b0, 1'b0, 1'b0, 32'h3C00_0000, "expm1");          ack("expm1");
        fr = '0;
        fr[FRAC_BITS-1] = 1'b1;
        launch(0, fr, 1'b0, 1'b0, 1'b0, 32'h4200_0000, "frac_msb");        ack("frac_msb");
        launch(0, fr, 1'b1, 1'b0, 1'b0, 32'hBE00_0000, "frac_msb_neg");    ack("frac_msb_neg");
        launch(240, '0, 1'b0, 1'b0, 1'b0, 32'h7FFF_FFFF, "maxpos");        ack("maxpos");
        launch(-256, '0, 1'b0, 1'b0, 1'b0, 32'h0000_0001, "minpos");       ack("minpos");
        launch(5, '1, 1'b1, 1'b1, 1'b1, 32'h8000_0000, "nar_zero");        ack("nar_zero");
        launch(5, '1, 1'b1, 1'b0, 1'b1, 32'h0000_0000, "zero");            ack("zero");

        // Result held while unacknowledged; start and new operands ignored in DONE.
        launch(9, '0, 1'b0, 1'b0, 1'b0, 32'h6200_0000, "hold");
        bus.start   = 1'b1;
        bus.exp_raw = (MAX_BITS+1)'(-1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold/done", N'(bus.done), N'(1));
            check("hold/posit", bus.posit_out, 32'h6200_0000);
        end
        bus.valid_out = 1'b1;
        @(negedge clk);
        check("hold/drop", N'(bus.done), N'(0));
        bus.valid_out = 1'b0;
        bus.start     = 1'b0;
        repeat (3) @(negedge clk);
        check("hold/idle_done", N'(bus.done), N'(0));
        check("hold/keep_posit", bus.posit_out, 32'h6200_0000);

        // Reset asserted while the packer is in PACK.
        @(negedge clk);
        bus.exp_raw = (MAX_BITS+1)'(9);
        bus.start   = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort/done", N'(bus.done), N'(0));
        check("abort/posit", bus.posit_out, N'(0));
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("abort/no_result", N'(bus.done), N'(0));
        end
        launch(-1, '0, 1'b0, 1'b0, 1'b0, 32'h3C00_0000, "after_abort");  ack("after_abort");

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 1) == 0)
                ex = int'($urandom_range(0, 80)) - 40;
            else
                ex = int'($urandom_range(0, EXP_MAX - EXP_MIN)) + EXP_MIN;
            fr   = FRAC_BITS'($urandom);
            s    = bit'($urandom_range(0, 1));
            nar  = ($urandom_range(0, 15) == 0);
            z    = ($urandom_range(0, 15) == 0);
            expv = ref_posit(ex, fr, s, nar, z);
            launch(ex, fr, s, nar, z, expv, "rand");
            ack("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/posit_packer.md
POSIT_PACKER -- requirements
Module: posit_packer

Interface
REQ-001 SHALL have parameter N, default 32, meaning total posit width in bits.
REQ-002 SHALL have parameter ES, default 3, meaning exponent field width in bits.
REQ-003 SHALL have parameter K_BITS, default 6, meaning signed regime value width.
REQ-004 SHALL have parameter MAX_BITS, default ES+K_BITS, meaning raw exponent magnitude width.
REQ-005 SHALL have parameter FRAC_BITS, default N-3-ES (26), meaning input fraction width, MSB-aligned, hidden bit excluded.
REQ-006 SHALL have port clk, input, 1, the single clock; one clock, all state on rising edge.
REQ-007 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port start, input, 1, request to pack the presented operands.
REQ-009 SHALL have port exp_raw, input, MAX_BITS+1, signed combined exponent k*2^ES+e.
REQ-010 SHALL have port frac_in, input, FRAC_BITS, fraction bits following the hidden 1.
REQ-011 SHALL have ports sign_in, NaR_in and zero_in, each input, 1: result sign, NaR flag and zero flag.
REQ-012 SHALL have port valid_out, input, 1, consumer acknowledge of the current result.
REQ-013 SHALL have port posit_out, output, N, encoded posit word.
REQ-014 SHALL have port done, output, 1, result valid, held until acknowledged.

Function
REQ-015 SHALL implement FSM IDLE -> SPLIT -> PACK -> DONE; IDLE->SPLIT when start=1; SPLIT->PACK and PACK->DONE unconditionally; DONE->IDLE when valid_out=1, else stay in DONE.
REQ-016 SHALL latch exp_raw, frac_in, sign_in, NaR_in and zero_in on the edge that takes IDLE->SPLIT; start outside IDLE is ignored.
REQ-017 SHALL in SPLIT compute k = exp_raw arithmetic-shift-right ES (floor) and e = exp_raw[ES-1:0], at MAX_BITS+1 width with no truncation.
REQ-018 SHALL in PACK form an N-1 bit body: regime (k>=0: k+1 ones then a 0; k<0: -k zeros then a 1), then e (ES bits), then frac, all truncated at the LSB (round toward zero, no rounding).
REQ-019 SHALL clamp k>=N-2 to maxpos magnitude (body all ones) and k<=-(N-1) to minpos magnitude (body = 1).
REQ-020 SHALL output {1'b0, body} when the sign is 0 and its two's complement when the sign is 1.
REQ-021 SHALL give priority NaR_in > zero_in > normal: NaR yields 1 followed by N-1 zeros (0x80000000); zero yields all zeros; the sign is ignored for both.
REQ-022 SHALL register posit_out and set done=1 on the PACK->DONE edge; done is visible after the 3rd rising edge counting the start-sampling edge.
REQ-023 SHALL clear done on the DONE->IDLE edge; posit_out holds its last value until the next PACK->DONE edge.
REQ-024 SHALL, if valid_out and start are both high in DONE, return to IDLE only; start is sampled again in IDLE.

Reset
REQ-025 SHALL on rst_n=0 force the state to IDLE and posit_out, done and all latched operands to 0, asynchronously, including mid-operation; no result from an aborted operation is ever presented.

Structure
REQ-026 SHALL place N, ES, K_BITS, MAX_BITS, FRAC_BITS, EXP_MAX, EXP_MIN, the state encodings and the NaR/maxpos/minpos constants in a shared posit package used with exp_adder.
REQ-027 SHALL use one sub-module, regime_encoder (combinational: k, e, frac -> N-1 bit body with clamping); the FSM, operand latching and sign stage stay in posit_packer.

Verification
REQ-028 SHALL check exp_raw=0, frac=0, sign=0 -> posit_out=0x40000000, done after 3 edges.
REQ-029 SHALL check exp_raw=9, frac=0 -> 0x62000000; exp_raw=-1, frac=0 -> 0x3C000000.
REQ-030 SHALL check exp_raw=0 with frac MSB=1 -> 0x42000000; the same with sign=1 -> 0xBE000000.
REQ-031 SHALL check exp_raw=240 -> 0x7FFFFFFF; exp_raw=-256 -> 0x00000001; NaR_in=1 with zero_in=1 -> 0x80000000.
REQ-032 SHALL check that done holds for 5 cycles with valid_out=0, then drops the cycle after valid_out=1, with start ignored while in DONE.
REQ-033 SHALL check rst_n pulsed low in PACK -> done=0, posit_out=0, state IDLE, and a following start completes normally.
